// File: rtl/seed_sequencer.sv
// Seed campaign sequencer: fetches each seed, resets/loads/starts the datapath, reports one result per seed.
// Optional feature: SEQ_STEADY_EXIT_EN ends a seed run early on the datapath steady-state flag.
module seed_sequencer #(
  parameter int unsigned STATE      = 16,
  parameter int unsigned LOG_RULES  = 5,
  parameter int unsigned NUM_SEEDS  = 200,
  parameter logic [9:0]  ITER_LIMIT = 10'd100,
  parameter int unsigned INHIBITOR  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic [9:0]           seed_addr,
  input  logic [STATE-1:0]     seed_data,
  output logic                 dp_rst,
  output logic                 ld_inhibitor,
  output logic [LOG_RULES-1:0] sel_inhibitor,
  output logic                 dp_start,
  output logic [STATE-1:0]     initial_state,
  input  logic [9:0]           iteration_number,
  input  logic                 steady_state,
  input  logic [STATE-1:0]     network_state,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [STATE-1:0]     res_state,
  output logic [9:0]           res_seed,
  output logic [9:0]           res_iter,
  output logic                 res_ss,
  output logic                 busy,
  output logic                 done
);

  localparam logic [LOG_RULES-1:0] INH_SEL  = LOG_RULES'(INHIBITOR);
  localparam logic [9:0]           LAST_IDX = 10'(NUM_SEEDS - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, CAPTURE, HOLD0, HOLD1, LOAD, GAP, START, SETTLE, RUN, REPORT, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       index_q, index_d;
  logic [STATE-1:0] init_q, init_d;
  logic [STATE-1:0] rstate_q, rstate_d;
  logic [9:0]       rseed_q, rseed_d;
  logic [9:0]       riter_q, riter_d;
  logic             rss_q, rss_d;
  logic             done_q, done_d;
  logic             run_exit;

  always_comb begin
`ifdef SEQ_STEADY_EXIT_EN
    run_exit = (iteration_number >= ITER_LIMIT) || steady_state;
`else
    run_exit = (iteration_number >= ITER_LIMIT);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      init_q   <= '0;
      rstate_q <= '0;
      rseed_q  <= '0;
      riter_q  <= '0;
      rss_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      init_q   <= init_d;
      rstate_q <= rstate_d;
      rseed_q  <= rseed_d;
      riter_q  <= riter_d;
      rss_q    <= rss_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    init_d   = init_q;
    rstate_d = rstate_q;
    rseed_d  = rseed_q;
    riter_d  = riter_q;
    rss_d    = rss_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = FETCH;
          index_d = '0;
          done_d  = 1'b0;
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        init_d  = seed_data;
        state_d = HOLD0;
      end
      HOLD0:   state_d = HOLD1;
      HOLD1:   state_d = LOAD;
      LOAD:    state_d = GAP;
      GAP:     state_d = START;
      START:   state_d = SETTLE;
      SETTLE:  state_d = RUN;
      RUN: begin
        if (run_exit) begin
          rstate_d = network_state;
          riter_d  = iteration_number;
          rss_d    = steady_state;
          rseed_d  = index_q;
          state_d  = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 10'd1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dp_rst is gated by rst directly so the datapath is held even before the reset edge lands.
  always_comb begin
    busy          = (state_q != IDLE) && (state_q != DONE);
    dp_rst        = ~rst && busy &&
                    !((state_q == FETCH) || (state_q == CAPTURE) ||
                      (state_q == HOLD0) || (state_q == HOLD1));
    seed_addr     = (state_q == FETCH) ? index_q : '0;
    ld_inhibitor  = (state_q == LOAD);
    dp_start      = (state_q == START);
    res_valid     = (state_q == REPORT);
    sel_inhibitor = ~INH_SEL;
    initial_state = init_q;
    res_state     = rstate_q;
    res_seed      = rseed_q;
    res_iter      = riter_q;
    res_ss        = rss_q;
    done          = done_q;
  end

endmodule

// File: tb/tb_seed_sequencer.sv
// Directed bench for seed_sequencer: 3-seed campaigns against a counting datapath model and seed memory.
module tb_seed_sequencer;

  logic        clk = 1'b0;
  logic        rst, go, res_ready;
  logic [9:0]  seed_addr;
  logic [15:0] seed_data;
  logic        dp_rst, ld_inhibitor, dp_start;
  logic [4:0]  sel_inhibitor;
  logic [15:0] initial_state, network_state, res_state;
  logic [9:0]  iteration_number, res_seed, res_iter;
  logic        steady_state, res_valid, res_ss, busy, done;

  int errors = 0;
  int checks = 0;
  int steady_at = 2000;

`ifdef SEQ_STEADY_EXIT_EN
  localparam bit STEADY_EXIT = 1'b1;
`else
  localparam bit STEADY_EXIT = 1'b0;
`endif

  typedef struct {
    logic [15:0] seed;
    logic [15:0] st_lim;  // seed + 100
    logic [15:0] st_ss;   // seed + 37
  } vec_t;
  vec_t vt [3];

  always #5 clk = ~clk;

  seed_sequencer #(.NUM_SEEDS(3)) dut (
    .clk(clk), .rst(rst), .go(go), .seed_addr(seed_addr), .seed_data(seed_data),
    .dp_rst(dp_rst), .ld_inhibitor(ld_inhibitor), .sel_inhibitor(sel_inhibitor),
    .dp_start(dp_start), .initial_state(initial_state),
    .iteration_number(iteration_number), .steady_state(steady_state),
    .network_state(network_state), .res_valid(res_valid), .res_ready(res_ready),
    .res_state(res_state), .res_seed(res_seed), .res_iter(res_iter), .res_ss(res_ss),
    .busy(busy), .done(done)
  );

  // Seed memory with one cycle read latency.
  always @(posedge clk)
    seed_data <= (seed_addr < 10'd3) ? vt[seed_addr].seed : 16'h0000;

  // Datapath model: counter restarts at 0 on dp_start, state = seed + count.
  logic [9:0] cnt = '0;
  logic       running = 1'b0;
  always @(posedge clk) begin
    if (!dp_rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (dp_start) begin
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      cnt <= cnt + 10'd1;
    end
  end
  assign iteration_number = cnt;
  assign steady_state     = running && (int'(cnt) >= steady_at);
  assign network_state    = initial_state + {6'b0, cnt};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse-shape monitor on every seed.
  int   cyc = 0, ld_t = 0, lowcnt = 0;
  logic prev_ld = 1'b0, prev_st = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!busy) lowcnt = 0;
    else if (!dp_rst) lowcnt++;
    else if (lowcnt != 0) begin
      chk("dp_rst_low_len", lowcnt, 4);
      lowcnt = 0;
    end
    if (ld_inhibitor) begin
      chk("ld_single", {31'b0, prev_ld}, 0);
      ld_t = cyc;
    end
    if (dp_start) begin
      chk("start_single", {31'b0, prev_st}, 0);
      chk("ld_to_start", cyc - ld_t, 2);
      chk("sel_inhibitor", {27'b0, sel_inhibitor}, 32'h1F);
    end
    prev_ld = ld_inhibitor;
    prev_st = dp_start;
  end

  task automatic run_campaign(input int stall, input bit steady, input bit extra_go);
    int n;
    bit early;
    early     = steady && STEADY_EXIT;
    steady_at = steady ? 37 : 2000;
    res_ready = (stall == 0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("go_busy", {31'b0, busy}, 1);
    chk("go_done_clr", {31'b0, done}, 0);
    chk("fetch_addr0", {22'b0, seed_addr}, 0);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!res_valid && n < 600) begin
        go = (extra_go && i == 0 && n == 40);
        @(negedge clk);
        n++;
      end
      go = 1'b0;
      if (!res_valid) begin
        chk("res_valid_timeout", {31'b0, res_valid}, 1);
        return;
      end
      chk("res_seed", {22'b0, res_seed}, i);
      chk("res_iter", {22'b0, res_iter}, early ? 37 : 100);
      chk("res_state", {16'b0, res_state}, early ? vt[i].st_ss : vt[i].st_lim);
      chk("res_ss", {31'b0, res_ss}, {31'b0, steady});
      chk("initial_state", {16'b0, initial_state}, {16'b0, vt[i].seed});
      if (stall > 0 && i == 0) begin
        repeat (stall) begin
          @(negedge clk);
          chk("stall_valid", {31'b0, res_valid}, 1);
          chk("stall_state", {16'b0, res_state}, vt[0].st_lim);
          chk("stall_seed", {22'b0, res_seed}, 0);
          chk("stall_iter", {22'b0, res_iter}, 100);
          chk("stall_no_fetch", {31'b0, dp_rst}, 1);
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
      chk("valid_drop", {31'b0, res_valid}, 0);
    end
    chk("done_set", {31'b0, done}, 1);
    chk("done_busy_clr", {31'b0, busy}, 0);
    @(negedge clk);
    chk("done_hold", {31'b0, done}, 1);
    chk("idle_busy", {31'b0, busy}, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_valid"}, {31'b0, res_valid}, 0);
    chk({tag, "_dp_rst"}, {31'b0, dp_rst}, 0);
    chk({tag, "_ld"}, {31'b0, ld_inhibitor}, 0);
    chk({tag, "_start"}, {31'b0, dp_start}, 0);
    chk({tag, "_addr"}, {22'b0, seed_addr}, 0);
    chk({tag, "_init"}, {16'b0, initial_state}, 0);
    chk({tag, "_rstate"}, {16'b0, res_state}, 0);
    chk({tag, "_rseed"}, {22'b0, res_seed}, 0);
    chk({tag, "_riter"}, {22'b0, res_iter}, 0);
    chk({tag, "_rss"}, {31'b0, res_ss}, 0);
    chk({tag, "_sel"}, {27'b0, sel_inhibitor}, 32'h1F);
  endtask

  initial begin
    int n;
    vt[0] = '{seed: 16'hA5A5, st_lim: 16'hA609, st_ss: 16'hA5CA};
    vt[1] = '{seed: 16'h0F0F, st_lim: 16'h0F73, st_ss: 16'h0F34};
    vt[2] = '{seed: 16'hFFFF, st_lim: 16'h0063, st_ss: 16'h0024};
    rst = 1'b1; go = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {31'b0, busy}, 0);

    run_campaign(0, 1'b0, 1'b0);
    run_campaign(7, 1'b0, 1'b0);
    run_campaign(0, 1'b0, 1'b1);

    // Reset during RUN of seed 1.
    res_ready = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!res_valid && n < 600) begin @(negedge clk); n++; end
    chk("mid_seed0_valid", {31'b0, res_valid}, 1);
    @(negedge clk);
    n = 0;
    while (!dp_start && n < 50) begin @(negedge clk); n++; end
    chk("mid_seed1_start", {31'b0, dp_start}, 1);
    repeat (10) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 1);
    chk("mid_seed0_kept", {22'b0, res_seed}, 0);
    rst = 1'b1;
    #1;
    chk("rst_dp_rst_gate", {31'b0, dp_rst}, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_stay_idle", {31'b0, busy}, 0);
    run_campaign(0, 1'b0, 1'b0);

    run_campaign(0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/seed_sequencer.md
SEED_SEQUENCER -- requirements
Module: seed_sequencer

Interface
REQ-001 Parameter STATE, default 16: network state width in bits.
REQ-002 Parameter LOG_RULES, default 5: inhibitor select width in bits.
REQ-003 Parameter NUM_SEEDS, default 200: number of seeds run per campaign, 1..1024.
REQ-004 Parameter ITER_LIMIT, default 10'd100: iteration count that ends one seed run.
REQ-005 Parameter INHIBITOR, default 0: inhibitor index; sel_inhibitor is its bitwise inverse.
REQ-006 Ports: clk, in, 1, the single clock; all logic is on its rising edge.
REQ-007 Ports: rst, in, 1, synchronous active-high reset.
REQ-008 Ports: go, in, 1, campaign start pulse.
REQ-009 Ports: seed_addr, out, 10, seed memory read address.
REQ-010 Ports: seed_data, in, STATE, seed memory read data, valid 1 cycle after seed_addr.
REQ-011 Ports: dp_rst, out, 1, datapath reset; low holds the datapath in reset.
REQ-012 Ports: ld_inhibitor, out, 1, inhibitor load pulse.
REQ-013 Ports: sel_inhibitor, out, LOG_RULES, constant ~INHIBITOR.
REQ-014 Ports: dp_start, out, 1, datapath start pulse.
REQ-015 Ports: initial_state, out, STATE, registered seed for the datapath.
REQ-016 Ports: iteration_number, in, 10, datapath iteration count.
REQ-017 Ports: steady_state, in, 1, datapath steady-state flag.
REQ-018 Ports: network_state, in, STATE, datapath state.
REQ-019 Ports: res_valid / res_ready, out / in, 1, result handshake.
REQ-020 Ports: res_state, res_seed, res_iter, res_ss, out, STATE / 10 / 10 / 1, result payload.
REQ-021 Ports: busy, done, out, 1, campaign in progress; campaign complete (sticky until next go).

Function
REQ-022 FSM states SHALL be IDLE, FETCH, CAPTURE, HOLD0, HOLD1, LOAD, GAP, START, SETTLE, RUN, REPORT, DONE.
REQ-023 IDLE: go=1 -> FETCH, seed index cleared to 0, done cleared; go ignored in all other states.
REQ-024 FETCH: drive seed_addr = index for 1 cycle -> CAPTURE.
REQ-025 CAPTURE: register seed_data into initial_state -> HOLD0.
REQ-026 HOLD0, HOLD1: dp_rst=0; after HOLD1 -> LOAD; dp_rst SHALL be 0 in FETCH through HOLD1, 1 otherwise while busy.
REQ-027 LOAD: ld_inhibitor=1 for exactly 1 cycle -> GAP (1 idle cycle) -> START.
REQ-028 START: dp_start=1 for exactly 1 cycle -> SETTLE (1 cycle) -> RUN.
REQ-029 RUN: exit to REPORT the first cycle iteration_number >= ITER_LIMIT (unsigned 10-bit compare); capture network_state, iteration_number, steady_state, index into the result registers on that cycle.
REQ-030 REPORT: res_valid=1 with stable payload until res_ready=1; res_valid and res_ready both high completes the transfer.
REQ-031 After transfer: index == NUM_SEEDS-1 -> DONE, else index+1 -> FETCH; no wrap of index.
REQ-032 DONE: done=1, busy=0 -> IDLE next cycle, done held until next go.
REQ-033 res_ready high outside REPORT SHALL have no effect; res_valid never asserted outside REPORT.
REQ-034 busy=1 in every state except IDLE and DONE.

Reset
REQ-035 rst=1 at any clock edge, including mid-run or mid-REPORT, SHALL force IDLE with the following cleared values: index 0, initial_state 0, result registers 0, res_valid 0, busy 0, done 0, ld_inhibitor 0, dp_start 0, seed_addr 0.
REQ-036 Under rst=1, dp_rst SHALL be 0; no pending result is retained.

Configuration
REQ-037 Macro SEQ_STEADY_EXIT_EN defined: RUN also exits to REPORT the first cycle steady_state=1, with res_ss=1.
REQ-038 Macro SEQ_STEADY_EXIT_EN undefined: steady_state is only sampled into res_ss; RUN exits only on ITER_LIMIT.

Verification
REQ-039 NUM_SEEDS=3, mem={A5A5,0F0F,FFFF}, res_ready=1, datapath model counts from 0 after dp_start -> 3 results with res_seed 0,1,2; each res_iter=100; done=1 after the third result.
REQ-040 Per seed -> dp_rst low exactly 4 cycles; ld_inhibitor pulses 1 cycle, dp_start pulses 1 cycle, with exactly 1 cycle between them; sel_inhibitor=~0.
REQ-041 res_ready held 0 for 7 cycles in REPORT -> res_valid and payload stable for the whole stall; no next FETCH until the handshake completes.
REQ-042 rst pulsed during RUN of seed 1 -> IDLE next cycle with all outputs at reset values; a new go restarts from seed 0.
REQ-043 SEQ_STEADY_EXIT_EN defined, steady_state=1 at iteration 37 -> res_iter=37 and res_ss=1; same stimulus with the macro undefined -> res_iter=100.
REQ-044 go pulsed while busy -> ignored; campaign results are unchanged.
